sha256_msg_schedule: RTL
========================

// Module: sha256_msg_schedule
// PURPOSE
//  Message-schedule producer for the SHA-256 core. Takes in one 512-bit block as 16 big-endian
//  32-bit words and streams out the 64 schedule words W[0..63] to the round/compression engine.
//  Uses small sigma0 (rotr7^rotr18^shr3) and small sigma1 (rotr17^rotr19^shr10), the
//  schedule-side counterparts of the round-side big-Sigma functions.
// PARAMETERS
//  WORDS_IN   16  words per block accepted before expansion (fixed by SHA-256; not for override)
//  WORDS_OUT  64  schedule words emitted per block
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   single-cycle pulse in IDLE: begin loading a new block
//  blk_word   in   32  message word input
//  blk_valid  in   1   blk_word is valid
//  blk_ready  out  1   block accepts blk_word (high only in LOAD)
//  w_data     out  32  schedule word W[t]
//  w_valid    out  1   w_data is valid
//  w_ready    in   1   consumer accepts w_data
//  busy       out  1   high in LOAD or EMIT
//  done       out  1   one-cycle pulse after W[63] is accepted
//  w_idx      out  6   index t of w_data (only when SCHED_IDX_EN is defined)
// BEHAVIOUR
//  - Reset: state=IDLE, win[0..15]=0, t=0, load count=0; blk_ready=0, w_valid=0, w_data=0,
//    busy=0, done=0, w_idx=0. Reset is honoured in any state, including mid-block; no partial output.
//  - FSM IDLE -> LOAD on start. start in LOAD or EMIT is ignored.
//  - LOAD: blk_ready=1. Each blk_valid&blk_ready shifts blk_word into win[15] (win[i]<=win[i+1]).
//    On the 16th accept go to EMIT; win[0]=W[0]...win[15]=W[15]. blk_valid low stalls, no timeout.
//  - EMIT: w_valid=1, w_data=win[0] (registered, no combinational path from inputs).
//    First w_valid is the cycle after the 16th input accept (1-cycle latency).
//    On w_valid&w_ready: t<=t+1; window shifts down by one; for t<48,
//    win[15]<=sig1(win[14])+win[9]+sig0(win[1])+win[0] (mod 2^32, carries dropped),
//    i.e. W[t+16]. For t>=48, shift in 0 (never emitted).
//    w_ready low holds w_data/window/t stable indefinitely.
//  - Accept with t=63: done=1 next cycle, w_valid=0, state IDLE, t=0. busy drops same edge.
//  - blk_ready=0 outside LOAD; input words offered in IDLE/EMIT are not consumed.
//  - start in the same cycle as the final W[63] accept is ignored (state is still EMIT).
// CONFIGURATION
//  SCHED_IDX_EN defined: w_idx port exists, = t while w_valid, reset 0, holds while stalled.
//  Not defined: port absent; all other behaviour identical.
// STRUCTURE
//  Shared package sha256_pkg: WORD_W=32, SCHED_WORDS=64, BLK_WORDS=16, state enum
//  {S_IDLE,S_LOAD,S_EMIT}, rotation constants 7/18/3 and 17/19/10.
//  One combinational sub-module sched_sigma #(R1,R2,S): rotr R1 ^ rotr R2 ^ shr S, instanced
//  twice (7,18,3) and (17,19,10). Adder, window, counters and FSM stay in this module.
// TESTING
//  1 "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> W16=0x61626380,
//    W17=0x000F0000; all 64 words match the golden model; done pulses once after word 63.
//  2 Random block with w_ready randomly toggled 50% -> identical 64-word sequence to 1-per-cycle
//    run; w_data stable while w_valid&!w_ready.
//  3 blk_valid gaps during LOAD (words 3 and 10 delayed 5 cycles) -> W sequence unchanged,
//    first w_valid exactly 1 cycle after 16th accept.
//  4 rst asserted at t=30 -> same cycle outputs to reset values; new start + all-zero block ->
//    W[0..63] all 0, no stale words from the previous block.
//  5 start pulsed during LOAD and EMIT, blk_valid held high in EMIT -> ignored, no extra loads,
//    blk_ready stays 0 in EMIT.
//  6 Back-to-back blocks: start the cycle after done -> second block correct; with SCHED_IDX_EN
//    w_idx steps 0..63 per block.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared widths, schedule sizes, FSM states and small-sigma rotation constants.
package sha256_pkg;
  localparam int WORD_W      = 32;
  localparam int SCHED_WORDS = 64;
  localparam int BLK_WORDS   = 16;
  localparam int S0_R1 = 7;
  localparam int S0_R2 = 18;
  localparam int S0_SH = 3;
  localparam int S1_R1 = 17;
  localparam int S1_R2 = 19;
  localparam int S1_SH = 10;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT} state_t;
endpackage

// File: rtl/sched_sigma.sv
// sched_sigma: small sigma function, rotr R1 ^ rotr R2 ^ shr S on one schedule word.
module sched_sigma
  import sha256_pkg::*;
#(
  parameter int R1 = 7,
  parameter int R2 = 18,
  parameter int S  = 3
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);
  assign y = ((x >> R1) | (x << (WORD_W - R1))) ^ ((x >> R2) | (x << (WORD_W - R2))) ^ (x >> S);
endmodule

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: loads 16 message words and streams the 64 SHA-256 schedule words W[0..63].
// Optional SCHED_IDX_EN macro adds the w_idx port carrying the index of w_data.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] blk_word,
  input  logic              blk_valid,
  output logic              blk_ready,
  output logic [WORD_W-1:0] w_data,
  output logic              w_valid,
  input  logic              w_ready,
`ifdef SCHED_IDX_EN
  output logic [5:0]        w_idx,
`endif
  output logic              busy,
  output logic              done
);
  localparam int WORDS_IN  = BLK_WORDS;
  localparam int WORDS_OUT = SCHED_WORDS;
  state_t state_q, state_d;
  logic [WORDS_IN-1:0][WORD_W-1:0] win_q, win_d;
  logic [5:0] t_q, t_d;
  logic [3:0] cnt_q, cnt_d;
  logic blk_ready_q, blk_ready_d, w_valid_q, w_valid_d, busy_q, busy_d, done_q, done_d;
  logic [WORD_W-1:0] s0, s1, next_w;
  logic acc_in, acc_out, last_in, last_out;
  sched_sigma #(.R1(S0_R1), .R2(S0_R2), .S(S0_SH)) u_s0 (.x(win_q[1]), .y(s0));
  sched_sigma #(.R1(S1_R1), .R2(S1_R2), .S(S1_SH)) u_s1 (.x(win_q[14]), .y(s1));
  always_comb begin
    acc_in   = state_q == S_LOAD && blk_valid;
    acc_out  = state_q == S_EMIT && w_ready;
    last_in  = acc_in && cnt_q == 4'(WORDS_IN - 1);
    last_out = acc_out && t_q == 6'(WORDS_OUT - 1);
    // the last 16 shifts feed zeros so the window is clean once the block ends
    next_w = t_q < 6'(WORDS_OUT - WORDS_IN) ? s1 + win_q[9] + s0 + win_q[0] : '0;
    state_d = (state_q == S_IDLE && start) ? S_LOAD :
              last_in ? S_EMIT : last_out ? S_IDLE : state_q;
    win_d = acc_in ? {blk_word, win_q[WORDS_IN-1:1]} :
            acc_out ? {next_w, win_q[WORDS_IN-1:1]} : win_q;
    cnt_d = acc_in ? cnt_q + 4'd1 : cnt_q;
    t_d = acc_out ? t_q + 6'd1 : t_q;
    blk_ready_d = state_d == S_LOAD;
    w_valid_d = state_d == S_EMIT;
    busy_d = state_d != S_IDLE;
    done_d = last_out;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      win_q       <= '0;
      t_q         <= '0;
      cnt_q       <= '0;
      blk_ready_q <= 1'b0;
      w_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      t_q         <= t_d;
      cnt_q       <= cnt_d;
      blk_ready_q <= blk_ready_d;
      w_valid_q   <= w_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
  assign blk_ready = blk_ready_q;
  assign w_data    = win_q[0];
  assign w_valid   = w_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef SCHED_IDX_EN
  assign w_idx = t_q;
`endif
endmodule
